// File: rtl/pong_game_ctrl_pkg.sv
// ============================================================
// pong_pkg : shared state encoding, side constants and BCD helpers
// Rev 1.0
// ============================================================
`default_nettype none

package pong_pkg;

  typedef enum logic [1:0] {
    ST_NEWGAME = 2'd0,
    ST_PLAY    = 2'd1,
    ST_NEWBALL = 2'd2,
    ST_OVER    = 2'd3
  } state_e;

  localparam logic SIDE_L = 1'b0;
  localparam logic SIDE_R = 1'b1;

  localparam int DEF_WIN_SCORE    = 7;
  localparam int DEF_TIMER_FRAMES = 120;
  localparam int DEF_REFRESH_Y    = 481;

  // Two-digit BCD increment; 99 wraps to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (v[3:0] >= 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (v[7:4] >= 4'd9) ? 4'd0 : v[7:4] + 4'd1;
    end else begin
      r[3:0] = v[3:0] + 4'd1;
    end
    return r;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    int t;
    int o;
    t = (v / 10) % 10;
    o = v % 10;
    return {4'(t), 4'(o)};
  endfunction

endpackage

`default_nettype wire

// File: rtl/pong_game_ctrl_if.sv
// ============================================================
// pong_game_ctrl_if : button/graphics inputs and score/status outputs
// Rev 1.0
// ============================================================
`default_nettype none

interface pong_game_ctrl_if;
  logic [3:0] btn;
  logic [9:0] x;
  logic [9:0] y;
  logic [1:0] hit;
  logic       miss;
  logic       gra_still;
  logic       game_over;
  logic       winner;
  logic [7:0] score_l;
  logic [7:0] score_r;
  logic [1:0] state_o;
  logic [7:0] rally_cnt;

  modport master (
    output btn, x, y, hit, miss,
    input  gra_still, game_over, winner, score_l, score_r, state_o, rally_cnt
  );

  modport slave (
    input  btn, x, y, hit, miss,
    output gra_still, game_over, winner, score_l, score_r, state_o, rally_cnt
  );
endinterface

`default_nettype wire

// File: rtl/pong_bcd_cnt.sv
// ============================================================
// pong_bcd_cnt : two-digit BCD counter, sync clear and increment
// Rev 1.0
// ============================================================
`default_nettype none

module pong_bcd_cnt
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr_i,
  input  logic       inc_i,
  output logic [7:0] cnt_o
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 8'h00;
    end else if (inc_i) begin
      cnt_d = bcd_inc(cnt_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 8'h00;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/pong_game_ctrl.sv
// ============================================================
// pong_game_ctrl : Pong game sequencing and scoring (macro PONG_RALLY_CNT_EN)
// Rev 1.0
// ============================================================
`default_nettype none

module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = DEF_WIN_SCORE,
  parameter int TIMER_FRAMES = DEF_TIMER_FRAMES,
  parameter int REFRESH_Y    = DEF_REFRESH_Y
) (
  input  logic             clk,
  input  logic             reset,
  pong_game_ctrl_if.slave  bus
);

  localparam int         TW         = (TIMER_FRAMES < 1) ? 1 : $clog2(TIMER_FRAMES + 1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMER_FRAMES);
  localparam logic [9:0] REFRESH_Y_C = 10'(REFRESH_Y);
  localparam logic [7:0] WIN_BCD     = to_bcd(WIN_SCORE);

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    btn_prev_q;
  logic [1:0]    hit_prev_q;
  logic          last_hitter_q, last_hitter_d;
  logic          hit_seen_q, hit_seen_d;
  logic          winner_q, winner_d;

  logic          refresh_tick;
  logic          any_start;
  logic [1:0]    hit_rise;
  logic          scorer;
  logic [7:0]    score_l, score_r;
  logic [7:0]    scorer_next;
  logic          win;
  logic          clr_scores, inc_l, inc_r, enter_play;

  assign refresh_tick = (bus.y == REFRESH_Y_C) && (bus.x == 10'd0);
  assign any_start    = |(bus.btn & ~btn_prev_q);
  assign hit_rise     = bus.hit & ~hit_prev_q;

  // A rally with no paddle contact means the left player missed the serve.
  assign scorer      = hit_seen_q ? last_hitter_q : SIDE_R;
  assign scorer_next = (scorer == SIDE_L) ? bcd_inc(score_l) : bcd_inc(score_r);
  assign win         = (scorer_next == WIN_BCD);

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    winner_d      = winner_q;
    last_hitter_d = last_hitter_q;
    hit_seen_d    = hit_seen_q;
    clr_scores    = 1'b0;
    inc_l         = 1'b0;
    inc_r         = 1'b0;
    enter_play    = 1'b0;

    unique case (state_q)
      ST_NEWGAME: begin
        if (any_start) begin
          clr_scores = 1'b1;
          enter_play = 1'b1;
          state_d    = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (bus.miss) begin
          inc_l   = (scorer == SIDE_L);
          inc_r   = (scorer == SIDE_R);
          timer_d = TIMER_LOAD;
          if (win) begin
            winner_d = scorer;
            state_d  = ST_OVER;
          end else begin
            state_d  = ST_NEWBALL;
          end
        end else if (hit_rise[1]) begin
          last_hitter_d = SIDE_R;
          hit_seen_d    = 1'b1;
        end else if (hit_rise[0]) begin
          last_hitter_d = SIDE_L;
          hit_seen_d    = 1'b1;
        end
      end
      ST_NEWBALL: begin
        if (refresh_tick) begin
          if (timer_q == '0) begin
            enter_play = 1'b1;
            state_d    = ST_PLAY;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
      end
      ST_OVER: begin
        if (refresh_tick) begin
          if (timer_q == '0) begin
            state_d = ST_NEWGAME;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
      end
      default: state_d = ST_NEWGAME;
    endcase

    if (enter_play) begin
      last_hitter_d = SIDE_L;
      hit_seen_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_NEWGAME;
      timer_q       <= '0;
      btn_prev_q    <= 4'hF;
      hit_prev_q    <= 2'b00;
      last_hitter_q <= SIDE_L;
      hit_seen_q    <= 1'b0;
      winner_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      btn_prev_q    <= bus.btn;
      hit_prev_q    <= bus.hit;
      last_hitter_q <= last_hitter_d;
      hit_seen_q    <= hit_seen_d;
      winner_q      <= winner_d;
    end
  end

  pong_bcd_cnt u_score_l (
    .clk   (clk),
    .reset (reset),
    .clr_i (clr_scores),
    .inc_i (inc_l),
    .cnt_o (score_l)
  );

  pong_bcd_cnt u_score_r (
    .clk   (clk),
    .reset (reset),
    .clr_i (clr_scores),
    .inc_i (inc_r),
    .cnt_o (score_r)
  );

`ifdef PONG_RALLY_CNT_EN
  logic [7:0] rally_q;

  // A hit coinciding with the miss is not part of the rally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rally_q <= 8'h00;
    end else if (enter_play) begin
      rally_q <= 8'h00;
    end else if ((state_q == ST_PLAY) && !bus.miss && (|hit_rise) && (rally_q != 8'hFF)) begin
      rally_q <= rally_q + 8'h01;
    end
  end

  assign bus.rally_cnt = rally_q;
`else
  assign bus.rally_cnt = 8'h00;
`endif

  assign bus.gra_still = (state_q != ST_PLAY);
  assign bus.game_over = (state_q == ST_OVER);
  assign bus.winner    = winner_q;
  assign bus.score_l   = score_l;
  assign bus.score_r   = score_r;
  assign bus.state_o   = state_q;

endmodule

`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
// ============================================================
// tb_pong_game_ctrl : directed and random checks against a rule-level model
// Rev 1.0
// ============================================================
`default_nettype none

module tb_pong_game_ctrl;

  localparam int WIN   = 12;
  localparam int TF    = 120;
  localparam int REF_Y = 481;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  pong_game_ctrl_if bus ();

  pong_game_ctrl #(
    .WIN_SCORE    (WIN),
    .TIMER_FRAMES (TF),
    .REFRESH_Y    (REF_Y)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: 0 new game, 1 play, 2 new ball, 3 over; scores held as integers.
  int         m_state, m_sl, m_sr, m_timer, m_rally;
  bit         m_last, m_seen, m_winner;
  logic [3:0] m_btn_prev;
  logic [1:0] m_hit_prev;

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) % 10) * 16 + (v % 10));
  endfunction

  task automatic m_reset();
    m_state = 0; m_sl = 0; m_sr = 0; m_timer = 0; m_rally = 0;
    m_last = 0; m_seen = 0; m_winner = 0;
    m_btn_prev = 4'hF; m_hit_prev = 2'b00;
  endtask

  task automatic m_enter_play();
    m_state = 1; m_last = 0; m_seen = 0; m_rally = 0;
  endtask

  task automatic m_step();
    bit         tick;
    bit         start;
    logic [1:0] hr;
    int         who;
    int         pts;
    tick  = (bus.y == 10'(REF_Y)) && (bus.x == 10'd0);
    start = |(bus.btn & ~m_btn_prev);
    hr    = bus.hit & ~m_hit_prev;
    case (m_state)
      0: if (start) begin m_sl = 0; m_sr = 0; m_enter_play(); end
      1: begin
        if (bus.miss) begin
          who = m_seen ? int'(m_last) : 1;
          if (who == 1) begin m_sr = (m_sr + 1) % 100; pts = m_sr; end
          else          begin m_sl = (m_sl + 1) % 100; pts = m_sl; end
          m_timer = TF;
          if (pts == WIN) begin m_winner = (who == 1); m_state = 3; end
          else m_state = 2;
        end else if (hr != 2'b00) begin
          m_last = hr[1];
          m_seen = 1;
          if (m_rally < 255) m_rally++;
        end
      end
      2: if (tick) begin if (m_timer == 0) m_enter_play(); else m_timer--; end
      default: if (tick) begin if (m_timer == 0) m_state = 0; else m_timer--; end
    endcase
    m_btn_prev = bus.btn;
    m_hit_prev = bus.hit;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [7:0] exp_rally;
`ifdef PONG_RALLY_CNT_EN
    exp_rally = 8'(m_rally);
`else
    exp_rally = 8'h00;
`endif
    chk("state",     {6'b0, bus.state_o}, 8'(m_state));
    chk("gra_still", {7'b0, bus.gra_still}, {7'b0, m_state != 1});
    chk("game_over", {7'b0, bus.game_over}, {7'b0, m_state == 3});
    chk("score_l",   bus.score_l, bcd(m_sl));
    chk("score_r",   bus.score_r, bcd(m_sr));
    chk("rally_cnt", bus.rally_cnt, exp_rally);
    if (m_state == 3) chk("winner", {7'b0, bus.winner}, {7'b0, m_winner});
  endtask

  task automatic cyc(input logic [3:0] b, input logic [1:0] h, input logic m, input bit tick);
    @(negedge clk);
    bus.btn = b; bus.hit = h; bus.miss = m;
    if (tick) begin bus.x = 10'd0; bus.y = 10'(REF_Y); end
    else begin bus.x = 10'(100 + $urandom_range(0, 500)); bus.y = 10'($urandom_range(0, 480)); end
    @(posedge clk);
    m_step();
    #1 check_all();
  endtask

  task automatic wait_play_or_idle();
    int n = 0;
    while ((m_state == 2 || m_state == 3) && n < 1000) begin
      cyc(4'h0, 2'b00, 1'b0, (n % 2) == 0);
      n++;
    end
  endtask

  task automatic do_point(input int kind);
    int n = 0;
    if (kind == 1) begin cyc(4'h0, 2'b01, 1'b0, 0); cyc(4'h0, 2'b00, 1'b0, 0); end
    if (kind == 2) begin cyc(4'h0, 2'b10, 1'b0, 0); cyc(4'h0, 2'b00, 1'b0, 0); end
    while (m_state == 1 && n < 4) begin cyc(4'h0, 2'b00, 1'b1, 0); n++; end
    cyc(4'h0, 2'b00, 1'b1, 0);
    cyc(4'h0, 2'b00, 1'b0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    m_reset();
    #1 check_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic start_game();
    cyc(4'h0, 2'b00, 1'b0, 0);
    cyc(4'b0001, 2'b00, 1'b0, 0);
    cyc(4'h0, 2'b00, 1'b0, 0);
  endtask

  initial begin
    logic [3:0] rb;
    logic [1:0] rh;
    logic       rm;
    checks = 0; failures = 0;
    reset = 1'b1;
    bus.btn = 4'b0100; bus.hit = 2'b00; bus.miss = 1'b0;
    bus.x = 10'd100; bus.y = 10'd100;
    m_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all();
    reset = 1'b0;

    // Button held through reset must not start a game.
    repeat (3) cyc(4'b0100, 2'b00, 1'b0, 0);
    chk("held_btn_newgame", {6'b0, bus.state_o}, 8'h00);
    cyc(4'h0, 2'b00, 1'b0, 0);
    cyc(4'b0001, 2'b00, 1'b0, 0);
    chk("start_play", {6'b0, bus.state_o}, 8'h01);
    cyc(4'h0, 2'b00, 1'b0, 0);

    // Serve missed with no hit: right scores.
    do_point(0);
    chk("serve_miss_r", bus.score_r, 8'h01);
    chk("serve_newball", {6'b0, bus.state_o}, 8'h02);
    wait_play_or_idle();
    chk("back_to_play", {6'b0, bus.state_o}, 8'h01);

    // Long hit pulses, then a long miss: one point to the right.
    repeat (5) cyc(4'h0, 2'b01, 1'b0, 0);
    repeat (3) cyc(4'h0, 2'b10, 1'b0, 0);
`ifdef PONG_RALLY_CNT_EN
    chk("rally_two", bus.rally_cnt, 8'h02);
`endif
    repeat (10) cyc(4'h0, 2'b00, 1'b1, 0);
    chk("once_r", bus.score_r, 8'h02);
    chk("once_l", bus.score_l, 8'h00);
    wait_play_or_idle();

    rb = 4'h0; rh = 2'b00; rm = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 15) == 0) rb = 4'($urandom);
      if ($urandom_range(0, 5) == 0) rh = 2'($urandom);
      if (m_state == 1 && !rm && $urandom_range(0, 29) == 0) rm = 1'b1;
      else if (m_state != 1 && rm && $urandom_range(0, 2) == 0) rm = 1'b0;
      cyc(rb, rh, rm, $urandom_range(0, 1) == 1);
    end

    // Right wins from 0 through the 09 -> 10 BCD carry to WIN.
    do_reset();
    start_game();
    for (int p = 0; p < WIN; p++) begin
      do_point(0);
      if (p == 9) chk("bcd_carry_r", bus.score_r, 8'h10);
      if (p < WIN - 1) wait_play_or_idle();
    end
    chk("over_r", {7'b0, bus.game_over}, 8'h01);
    chk("winner_r", {7'b0, bus.winner}, 8'h01);
    wait_play_or_idle();
    chk("retained_r", bus.score_r, 8'h12);

    // Left wins with a hit before every miss.
    start_game();
    for (int p = 0; p < WIN; p++) begin
      do_point(1);
      if (p < WIN - 1) wait_play_or_idle();
    end
    chk("over_l", {7'b0, bus.game_over}, 8'h01);
    chk("winner_l", {7'b0, bus.winner}, 8'h00);
    wait_play_or_idle();
    chk("retained_l", bus.score_l, 8'h12);

    // Asynchronous reset mid-NEWBALL.
    start_game();
    cyc(4'h0, 2'b01, 1'b0, 0);
    do_point(2);
    for (int n = 0; n < 400 && m_timer > 50; n++) cyc(4'h0, 2'b00, 1'b0, (n % 2) == 0);
    do_reset();
    chk("rst_state", {6'b0, bus.state_o}, 8'h00);
    chk("rst_score_r", bus.score_r, 8'h00);
    chk("rst_rally", bus.rally_cnt, 8'h00);
    cyc(4'h0, 2'b00, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
